// File: rtl/pulse_pattern_gen.sv
// Programmable pulse-train generator: emits num_pulses pulses (or runs forever)
// with configurable high/low phase lengths; all outputs are registered.
module pulse_pattern_gen #(
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enb,
  input  logic             start,
  input  logic [CNT_W-1:0] high_len,
  input  logic [CNT_W-1:0] low_len,
  input  logic [CNT_W-1:0] num_pulses,
  output logic             sig_out,
  output logic             rise,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulse_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] hlen_q, hlen_d;
  logic [CNT_W-1:0] llen_q, llen_d;
  logic [CNT_W-1:0] npul_q, npul_d;
  logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic             sig_out_q, sig_out_d;
  logic             rise_q, rise_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-state and next-output logic; outputs are computed for the state being entered
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    hlen_d      = hlen_q;
    llen_d      = llen_q;
    npul_d      = npul_q;
    pulse_cnt_d = pulse_cnt_q;
    sig_out_d   = 1'b0;
    rise_d      = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    if (!enb) begin
      state_d     = ST_IDLE;
      phase_d     = ZERO;
      hlen_d      = ZERO;
      llen_d      = ZERO;
      npul_d      = ZERO;
      pulse_cnt_d = ZERO;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            // Zero lengths are stored as 1 so phase compares never underflow
            hlen_d      = (high_len == ZERO) ? ONE : high_len;
            llen_d      = (low_len == ZERO) ? ONE : low_len;
            npul_d      = num_pulses;
            state_d     = ST_HIGH;
            phase_d     = ZERO;
            pulse_cnt_d = ONE;
            sig_out_d   = 1'b1;
            rise_d      = 1'b1;
            busy_d      = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_HIGH: begin
          busy_d = 1'b1;
          if (phase_q == (hlen_q - ONE)) begin
            state_d   = ST_LOW;
            phase_d   = ZERO;
            sig_out_d = 1'b0;
          end else begin
            phase_d   = phase_q + ONE;
            sig_out_d = 1'b1;
          end
        end
        ST_LOW: begin
          busy_d = 1'b1;
          if (phase_q == (llen_q - ONE)) begin
            phase_d = ZERO;
            if ((npul_q == ZERO) || (pulse_cnt_q < npul_q)) begin
              state_d     = ST_HIGH;
              pulse_cnt_d = pulse_cnt_q + ONE;
              sig_out_d   = 1'b1;
              rise_d      = 1'b1;
            end else begin
              state_d = ST_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            phase_d = phase_q + ONE;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d     = ST_IDLE;
          phase_d     = ZERO;
          pulse_cnt_d = ZERO;
        end
      endcase
    end
  end

  // State, configuration and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      phase_q     <= ZERO;
      hlen_q      <= ZERO;
      llen_q      <= ZERO;
      npul_q      <= ZERO;
      pulse_cnt_q <= ZERO;
      sig_out_q   <= 1'b0;
      rise_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      hlen_q      <= hlen_d;
      llen_q      <= llen_d;
      npul_q      <= npul_d;
      pulse_cnt_q <= pulse_cnt_d;
      sig_out_q   <= sig_out_d;
      rise_q      <= rise_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign sig_out   = sig_out_q;
  assign rise      = rise_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pulse_cnt = pulse_cnt_q;

endmodule
